// File: rtl/lcd_byte_writer_pkg.sv
// Shared types and constants for the character-LCD byte writer: FSM states,
// init nibbles and default datasheet timings (cycles at 50 MHz).
package lcd_byte_writer_pkg;

    typedef enum logic [3:0] {
        ST_PWRUP,
        ST_INIT_SETUP,
        ST_INIT_E,
        ST_INIT_HOLD,
        ST_INIT_GAP,
        ST_IDLE,
        ST_SETUP,
        ST_E_HIGH,
        ST_HOLD,
        ST_GAP
    } lcd_state_e;

    localparam int unsigned CNT_W   = 20;
    localparam int unsigned ENTRY_W = 9;

    localparam logic [3:0] INIT_NIB_8BIT = 4'h3;
    localparam logic [3:0] INIT_NIB_4BIT = 4'h2;
    localparam logic [1:0] INIT_LAST     = 2'd3;

    localparam int unsigned DEF_CLK_POWERUP    = 750000;
    localparam int unsigned DEF_CLK_INIT_GAP   = 205000;
    localparam int unsigned DEF_CLK_SETUP      = 2;
    localparam int unsigned DEF_CLK_EPULSE     = 12;
    localparam int unsigned DEF_CLK_HOLD       = 1;
    localparam int unsigned DEF_CLK_NIBBLE_GAP = 50;
    localparam int unsigned DEF_CLK_BYTE_GAP   = 2000;

    // Three "function set 8-bit" nibbles, then the switch to 4-bit mode.
    function automatic logic [3:0] init_nibble(input logic [1:0] idx);
        return (idx == INIT_LAST) ? INIT_NIB_4BIT : INIT_NIB_8BIT;
    endfunction

endpackage

// File: rtl/lcd_byte_writer_sync_fifo.sv
// Synchronous FIFO, registered pointers/count; read data is the head entry.
// Push on full and pop on empty are ignored; simultaneous push/pop keeps count.
module lcd_byte_writer_sync_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push, do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/lcd_byte_writer.sv
// HD44780-style 4-bit write-only LCD driver: buffers {RS,byte} from the CPU,
// runs the power-on init, then strobes each byte out as two timed nibbles.
module lcd_byte_writer
    import lcd_byte_writer_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned CLK_POWERUP    = DEF_CLK_POWERUP,
    parameter int unsigned CLK_INIT_GAP   = DEF_CLK_INIT_GAP,
    parameter int unsigned CLK_SETUP      = DEF_CLK_SETUP,
    parameter int unsigned CLK_EPULSE     = DEF_CLK_EPULSE,
    parameter int unsigned CLK_HOLD       = DEF_CLK_HOLD,
    parameter int unsigned CLK_NIBBLE_GAP = DEF_CLK_NIBBLE_GAP,
    parameter int unsigned CLK_BYTE_GAP   = DEF_CLK_BYTE_GAP
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [7:0] iData,
    input  logic       iRS,
    input  logic       iValid,
    output logic       oReady,
    output logic       oInitDone,
    output logic       oBusy,
    output logic       oLCD_E,
    output logic       oLCD_RS,
    output logic       oLCD_RW,
    output logic [3:0] oLCD_Data
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    lcd_state_e         state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [1:0]         init_idx_q;
    logic               init_done_q, e_q, rs_q, lower_q, ready_en_q;
    logic [3:0]         dat_q, lo_q;

    logic               fifo_push, fifo_pop, fifo_full, fifo_empty, cnt_done;
    logic [ENTRY_W-1:0] fifo_rdat;
    logic [CW-1:0]      fifo_cnt;

    // Every state lasts N cycles: load N-1 on entry, leave when it reaches 0.
    function automatic logic [CNT_W-1:0] cyc(input int unsigned n);
        return CNT_W'(n - 1);
    endfunction

    assign cnt_done  = (cnt_q == '0);
    assign oReady    = ready_en_q && !fifo_full;
    assign fifo_push = iValid && oReady;
    assign fifo_pop  = (state_q == ST_IDLE) && !fifo_empty;

    lcd_byte_writer_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (Clock),
        .rst_ni  (Reset),
        .push_i  (fifo_push),
        .wdata_i ({iRS, iData}),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdat),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_cnt)
    );

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q     <= ST_PWRUP;
            cnt_q       <= cyc(CLK_POWERUP);
            init_idx_q  <= '0;
            init_done_q <= 1'b0;
            e_q         <= 1'b0;
            rs_q        <= 1'b0;
            dat_q       <= '0;
            lo_q        <= '0;
            lower_q     <= 1'b0;
            ready_en_q  <= 1'b0;
        end else begin
            ready_en_q <= 1'b1;
            if (!cnt_done) cnt_q <= cnt_q - 1'b1;
            case (state_q)
                ST_PWRUP: if (cnt_done) begin
                    state_q <= ST_INIT_SETUP;
                    cnt_q   <= cyc(CLK_SETUP);
                    rs_q    <= 1'b0;
                    dat_q   <= init_nibble(init_idx_q);
                end
                ST_INIT_SETUP: if (cnt_done) begin
                    state_q <= ST_INIT_E;
                    cnt_q   <= cyc(CLK_EPULSE);
                    e_q     <= 1'b1;
                end
                ST_INIT_E: if (cnt_done) begin
                    state_q <= ST_INIT_HOLD;
                    cnt_q   <= cyc(CLK_HOLD);
                    e_q     <= 1'b0;
                end
                ST_INIT_HOLD: if (cnt_done) begin
                    state_q <= ST_INIT_GAP;
                    cnt_q   <= cyc(CLK_INIT_GAP);
                end
                ST_INIT_GAP: if (cnt_done) begin
                    if (init_idx_q == INIT_LAST) begin
                        state_q     <= ST_IDLE;
                        init_done_q <= 1'b1;
                    end else begin
                        state_q    <= ST_INIT_SETUP;
                        cnt_q      <= cyc(CLK_SETUP);
                        init_idx_q <= init_idx_q + 1'b1;
                        dat_q      <= init_nibble(init_idx_q + 2'd1);
                    end
                end
                ST_IDLE: if (!fifo_empty) begin
                    state_q <= ST_SETUP;
                    cnt_q   <= cyc(CLK_SETUP);
                    rs_q    <= fifo_rdat[8];
                    dat_q   <= fifo_rdat[7:4];
                    lo_q    <= fifo_rdat[3:0];
                    lower_q <= 1'b0;
                end
                ST_SETUP: if (cnt_done) begin
                    state_q <= ST_E_HIGH;
                    cnt_q   <= cyc(CLK_EPULSE);
                    e_q     <= 1'b1;
                end
                ST_E_HIGH: if (cnt_done) begin
                    state_q <= ST_HOLD;
                    cnt_q   <= cyc(CLK_HOLD);
                    e_q     <= 1'b0;
                end
                ST_HOLD: if (cnt_done) begin
                    state_q <= ST_GAP;
                    cnt_q   <= lower_q ? cyc(CLK_BYTE_GAP) : cyc(CLK_NIBBLE_GAP);
                end
                ST_GAP: if (cnt_done) begin
                    if (lower_q) begin
                        state_q <= ST_IDLE;
                    end else begin
                        state_q <= ST_SETUP;
                        cnt_q   <= cyc(CLK_SETUP);
                        dat_q   <= lo_q;
                        lower_q <= 1'b1;
                    end
                end
                default: state_q <= ST_PWRUP;
            endcase
        end
    end

    // Init states are reported through oInitDone, not oBusy.
    assign oBusy = (fifo_cnt != '0) ||
                   (state_q inside {ST_SETUP, ST_E_HIGH, ST_HOLD, ST_GAP});
    assign oInitDone = init_done_q;
    assign oLCD_E    = e_q;
    assign oLCD_RS   = rs_q;
    assign oLCD_Data = dat_q;
    assign oLCD_RW   = 1'b0;

endmodule

// File: tb/tb_lcd_byte_writer.sv
// Scoreboard bench for lcd_byte_writer with scaled timings: every expected
// {RS,nibble} is queued at handshake/reset and checked on each E pulse.
module tb_lcd_byte_writer;
    localparam int unsigned P_POWERUP = 20;
    localparam int unsigned P_INITGAP = 10;
    localparam int unsigned P_SETUP   = 2;
    localparam int unsigned P_EPULSE  = 3;
    localparam int unsigned P_HOLD    = 1;
    localparam int unsigned P_NGAP    = 4;
    localparam int unsigned P_BGAP    = 8;

    logic       Clock, Reset, iRS, iValid;
    logic [7:0] iData;
    logic       oReady, oInitDone, oBusy, oLCD_E, oLCD_RS, oLCD_RW;
    logic [3:0] oLCD_Data;

    int checks = 0;
    int errors = 0;
    logic [4:0] exp_q[$];

    lcd_byte_writer #(
        .FIFO_DEPTH     (4),
        .CLK_POWERUP    (P_POWERUP),
        .CLK_INIT_GAP   (P_INITGAP),
        .CLK_SETUP      (P_SETUP),
        .CLK_EPULSE     (P_EPULSE),
        .CLK_HOLD       (P_HOLD),
        .CLK_NIBBLE_GAP (P_NGAP),
        .CLK_BYTE_GAP   (P_BGAP)
    ) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .iData     (iData),
        .iRS       (iRS),
        .iValid    (iValid),
        .oReady    (oReady),
        .oInitDone (oInitDone),
        .oBusy     (oBusy),
        .oLCD_E    (oLCD_E),
        .oLCD_RS   (oLCD_RS),
        .oLCD_RW   (oLCD_RW),
        .oLCD_Data (oLCD_Data)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic push_init_expect();
        exp_q.push_back({1'b0, 4'h3});
        exp_q.push_back({1'b0, 4'h3});
        exp_q.push_back({1'b0, 4'h3});
        exp_q.push_back({1'b0, 4'h2});
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic rs, input logic [7:0] d, output int waited);
        waited = 0;
        iRS    = rs;
        iData  = d;
        iValid = 1'b1;
        while (!oReady && waited < 2000) begin
            @(negedge Clock);
            waited++;
        end
        if (!oReady) begin
            iValid = 1'b0;
            chk("send_timeout", 32'd1, 32'd0);
        end else begin
            exp_q.push_back({rs, d[7:4]});
            exp_q.push_back({rs, d[3:0]});
        end
        @(negedge Clock);
    endtask

    task automatic wait_e(input logic v, input string tag);
        int n = 0;
        while (oLCD_E !== v && n < 1000) begin
            @(negedge Clock);
            n++;
        end
        if (oLCD_E !== v) chk(tag, 32'(oLCD_E), 32'(v));
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while ((exp_q.size() != 0 || oBusy) && n < 3000) begin
            @(negedge Clock);
            n++;
        end
        chk(tag, 32'(exp_q.size()), 32'd0);
        chk("drain_busy", 32'(oBusy), 32'd0);
    endtask

    // Pulse monitor: width, stability and scoreboard compare at each E fall.
    initial begin
        logic       prev_e = 1'b0, unstable = 1'b0, mrs = 1'b0;
        logic [3:0] mdat = '0;
        logic [4:0] e;
        int         w = 0;
        forever begin
            @(negedge Clock);
            if (!Reset) begin
                prev_e = 1'b0;
            end else begin
                if (oLCD_E && !prev_e) begin
                    w = 1; mdat = oLCD_Data; mrs = oLCD_RS; unstable = 1'b0;
                end else if (oLCD_E) begin
                    w++;
                    if (oLCD_Data !== mdat || oLCD_RS !== mrs) unstable = 1'b1;
                end else if (prev_e) begin
                    if (exp_q.size() == 0) begin
                        chk("extra_pulse", 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("nib_data", 32'(mdat), 32'(e[3:0]));
                        chk("nib_rs", 32'(mrs), 32'(e[4]));
                        chk("hold_data", 32'(oLCD_Data), 32'(e[3:0]));
                        chk("e_width", 32'(w), 32'(P_EPULSE));
                        chk("e_stable", 32'(unstable), 32'd0);
                        chk("rw_low", 32'(oLCD_RW), 32'd0);
                    end
                end
                prev_e = oLCD_E;
            end
        end
    end

    initial begin
        int n, w, wmax;
        iValid = 1'b0; iRS = 1'b0; iData = '0;
        Reset = 1'b1;
        #2 Reset = 1'b0;
        #1;
        chk("rst_ready", 32'(oReady), 32'd0);
        chk("rst_initdone", 32'(oInitDone), 32'd0);
        chk("rst_busy", 32'(oBusy), 32'd0);
        chk("rst_e", 32'(oLCD_E), 32'd0);
        chk("rst_rs", 32'(oLCD_RS), 32'd0);
        chk("rst_data", 32'(oLCD_Data), 32'd0);
        chk("rst_rw", 32'(oLCD_RW), 32'd0);
        push_init_expect();
        repeat (2) @(negedge Clock);
        Reset = 1'b1;

        // Init sequence with no input
        for (int i = 0; i < 4; i++) begin
            wait_e(1'b1, "init_rise_timeout");
            wait_e(1'b0, "init_fall_timeout");
        end
        n = 0;
        while (!oInitDone && n < 100) begin
            @(negedge Clock);
            n++;
        end
        chk("init_done_delay", 32'(n), 32'(P_HOLD + P_INITGAP));
        chk("init_busy", 32'(oBusy), 32'd0);
        chk("init_pulses_left", 32'(exp_q.size()), 32'd0);

        // Single character byte: nibble spacing and busy tail
        send(1'b1, 8'h41, w);
        iValid = 1'b0;
        wait_e(1'b1, "b41_rise_timeout");
        wait_e(1'b0, "b41_fall_timeout");
        n = 0;
        while (!oLCD_E && n < 100) begin
            @(negedge Clock);
            n++;
        end
        chk("nibble_gap", 32'(n), 32'(P_HOLD + P_NGAP + P_SETUP));
        wait_e(1'b0, "b41_fall2_timeout");
        n = 0;
        while (oBusy && n < 100) begin
            @(negedge Clock);
            n++;
        end
        chk("busy_tail", 32'(n), 32'(P_HOLD + P_BGAP));

        // Command then data: RS switch and nibble order
        send(1'b0, 8'h01, w);
        send(1'b1, 8'hFF, w);
        iValid = 1'b0;
        wait_drain("drain_cmd_data");

        // Hold iValid through a full FIFO
        wmax = 0;
        for (int i = 0; i < 6; i++) begin
            send(i[0], 8'(8'h60 + i), w);
            if (w > wmax) wmax = w;
        end
        iValid = 1'b0;
        chk("full_stall", 32'(wmax > 0), 32'd1);
        wait_drain("drain_full");

        // Reset in the middle of an E pulse
        send(1'b0, 8'h38, w);
        iValid = 1'b0;
        wait_e(1'b1, "b38_rise_timeout");
        #2 Reset = 1'b0;
        exp_q.delete();
        push_init_expect();
        #1;
        chk("abort_e", 32'(oLCD_E), 32'd0);
        chk("abort_initdone", 32'(oInitDone), 32'd0);
        chk("abort_busy", 32'(oBusy), 32'd0);
        chk("abort_ready", 32'(oReady), 32'd0);
        repeat (3) @(negedge Clock);
        Reset = 1'b1;

        // Five bytes back-to-back during the rerun init
        repeat (2) @(negedge Clock);
        wmax = 0;
        for (int i = 0; i < 4; i++) begin
            send(1'b1, 8'(8'h30 + i), w);
            if (w > wmax) wmax = w;
        end
        chk("init_accept_stall", 32'(wmax), 32'd0);
        chk("init_full_ready", 32'(oReady), 32'd0);
        chk("init_full_initdone", 32'(oInitDone), 32'd0);
        send(1'b1, 8'h34, w);
        iValid = 1'b0;
        chk("fifth_stalled", 32'(w > 0), 32'd1);
        wait_drain("drain_init_burst");
        chk("final_initdone", 32'(oInitDone), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
